// File: rtl/action_dispatch.sv
// ---------------------------------------------------------------------------
// action_dispatch
//
// Purpose:
//   Turns the TCAM hit / action-memory result of each parsed packet into a
//   decoded forwarding verdict. Verdicts go through a small first-word-
//   fall-through FIFO that drains toward egress over valid/ready. Each lookup
//   also bumps a saturating hit counter: one per entry, plus one for misses.
//   Counters are read over a registered read port and can be zeroed by a
//   background clear sweep.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_act_valid           one-cycle result strobe (no upstream backpressure)
//   i_act_hit             TCAM hit for this result
//   i_act_index           matching entry, valid when i_act_hit
//   i_act_data            action word, valid when i_act_hit
//   i_miss_action         default action word, used on a miss
//   o_vd_valid            verdict available at the FIFO head
//   i_vd_ready            egress accepts the head verdict
//   o_vd_opcode           00 FWD, 01 DROP, 10 TO_CPU, 11 MIRROR
//   o_vd_port/o_vd_queue  egress port / queue
//   o_vd_dscp_wr/o_vd_dscp  DSCP rewrite enable / value
//   o_vd_vlan_wr/o_vd_vlan  VLAN rewrite enable / value
//   o_vd_hit/o_vd_index   verdict source (index is 0 on a miss)
//   i_cnt_rd_en/i_cnt_rd_addr/o_cnt_rd_data  counter read port, 1-cycle latency;
//                         address ENTRIES is the miss counter
//   i_cnt_clr_all         pulse: start the clear sweep
//   o_cnt_busy            clear sweep in progress
//   o_ovf_cnt             verdicts dropped because the FIFO was full
//
// Clear FSM:
//   state   | meaning
//   S_IDLE  | no sweep; waiting for i_cnt_clr_all
//   S_SWEEP | zeroing counter r_sweep_addr this cycle (0..ENTRIES)
// ---------------------------------------------------------------------------
module action_dispatch #(
  parameter int ENTRIES    = 16,
  parameter int ACTION_W   = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = $clog2(ENTRIES)
) (
  input  logic                i_clk,
  input  logic                i_rst,

  input  logic                i_act_valid,
  input  logic                i_act_hit,
  input  logic [IDX_W-1:0]    i_act_index,
  input  logic [ACTION_W-1:0] i_act_data,
  input  logic [ACTION_W-1:0] i_miss_action,

  output logic                o_vd_valid,
  input  logic                i_vd_ready,
  output logic [1:0]          o_vd_opcode,
  output logic [3:0]          o_vd_port,
  output logic [2:0]          o_vd_queue,
  output logic                o_vd_dscp_wr,
  output logic [5:0]          o_vd_dscp,
  output logic                o_vd_vlan_wr,
  output logic [11:0]         o_vd_vlan,
  output logic                o_vd_hit,
  output logic [IDX_W-1:0]    o_vd_index,

  input  logic                i_cnt_rd_en,
  input  logic [IDX_W:0]      i_cnt_rd_addr,
  output logic [CNT_W-1:0]    o_cnt_rd_data,
  input  logic                i_cnt_clr_all,
  output logic                o_cnt_busy,
  output logic [15:0]         o_ovf_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [IDX_W:0]   MISS_ADDR = (IDX_W+1)'(ENTRIES);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   OCC_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [15:0]      OVF_MAX   = 16'hFFFF;

  typedef struct packed {
    logic [1:0]       opcode;
    logic [3:0]       port;
    logic [2:0]       queue;
    logic             dscp_wr;
    logic [5:0]       dscp;
    logic             vlan_wr;
    logic [11:0]      vlan;
    logic             hit;
    logic [IDX_W-1:0] index;
  } verdict_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Action decode
  // -------------------------------------------------------------------------
  logic [ACTION_W-1:0] w_act_word;
  verdict_t            w_new_vd;
  logic                w_unused;

  assign w_act_word = i_act_hit ? i_act_data : i_miss_action;
  // Reserved low bits of the action word carry no meaning for dispatch.
  assign w_unused   = ^w_act_word[34:0];

  always_comb begin
    w_new_vd         = '0;
    w_new_vd.opcode  = w_act_word[63:62];
    w_new_vd.port    = w_act_word[61:58];
    w_new_vd.queue   = w_act_word[57:55];
    w_new_vd.dscp_wr = w_act_word[54];
    w_new_vd.dscp    = w_act_word[53:48];
    w_new_vd.vlan_wr = w_act_word[47];
    w_new_vd.vlan    = w_act_word[46:35];
    w_new_vd.hit     = i_act_hit;
    w_new_vd.index   = i_act_hit ? i_act_index : '0;
  end

  // -------------------------------------------------------------------------
  // Verdict FIFO (first-word-fall-through)
  // -------------------------------------------------------------------------
  verdict_t         r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [15:0]      r_ovf_cnt;

  logic     w_full;
  logic     w_pop;
  logic     w_push;
  logic     w_ovf;
  verdict_t w_head;
  verdict_t w_vd_out;

  assign o_vd_valid = (r_count != '0);
  assign w_full     = (r_count == FIFO_FULL);
  assign w_pop      = o_vd_valid && i_vd_ready;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push     = i_act_valid && (!w_full || w_pop);
  assign w_ovf      = i_act_valid && w_full && !w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_new_vd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
      if (w_ovf && (r_ovf_cnt != OVF_MAX)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  // Head fields are forced to zero while empty so stale slots never show.
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_vd_out = o_vd_valid ? w_head : '0;

  assign o_vd_opcode  = w_vd_out.opcode;
  assign o_vd_port    = w_vd_out.port;
  assign o_vd_queue   = w_vd_out.queue;
  assign o_vd_dscp_wr = w_vd_out.dscp_wr;
  assign o_vd_dscp    = w_vd_out.dscp;
  assign o_vd_vlan_wr = w_vd_out.vlan_wr;
  assign o_vd_vlan    = w_vd_out.vlan;
  assign o_vd_hit     = w_vd_out.hit;
  assign o_vd_index   = w_vd_out.index;
  assign o_ovf_cnt    = r_ovf_cnt;

  // -------------------------------------------------------------------------
  // Clear-sweep FSM
  // -------------------------------------------------------------------------
  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDX_W:0] r_sweep_addr;
  logic           w_sweep_clr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cnt_clr_all) begin
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_sweep_clr = 1'b1;
        if (r_sweep_addr == MISS_ADDR) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sweep_addr <= '0;
    end else if (r_state == S_SWEEP) begin
      r_sweep_addr <= r_sweep_addr + (IDX_W+1)'(1);
    end else begin
      r_sweep_addr <= '0;
    end
  end

  assign o_cnt_busy = (r_state == S_SWEEP);

  // -------------------------------------------------------------------------
  // Hit counters: entries 0..ENTRIES-1, miss counter at ENTRIES
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt [ENTRIES+1];
  logic [IDX_W:0]   w_inc_addr;
  logic [CNT_W-1:0] w_rd_val;
  logic [CNT_W-1:0] r_rd_data;

  assign w_inc_addr = i_act_hit ? {1'b0, i_act_index} : MISS_ADDR;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i <= ENTRIES; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= ENTRIES; i++) begin
        if (w_sweep_clr && (r_sweep_addr == (IDX_W+1)'(i))) begin
          // A lookup landing on the slot being cleared is counted afresh.
          if (i_act_valid && (w_inc_addr == (IDX_W+1)'(i))) begin
            r_cnt[i] <= CNT_ONE;
          end else begin
            r_cnt[i] <= '0;
          end
        end else if (i_act_valid && (w_inc_addr == (IDX_W+1)'(i)) &&
                     (r_cnt[i] != CNT_MAX)) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Addresses above the miss counter fall through to zero.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i <= ENTRIES; i++) begin
      if (i_cnt_rd_addr == (IDX_W+1)'(i)) begin
        w_rd_val = r_cnt[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= '0;
    end else if (i_cnt_rd_en) begin
      r_rd_data <= w_rd_val;
    end
  end

  assign o_cnt_rd_data = r_rd_data;

endmodule

// File: tb/tb_action_dispatch.sv
module tb_action_dispatch;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 8;

  logic              clk;
  logic              rst;
  logic              act_valid;
  logic              act_hit;
  logic [IDX_W-1:0]  act_index;
  logic [63:0]       act_data;
  logic [63:0]       miss_action;
  logic              vd_valid;
  logic              vd_ready;
  logic [1:0]        vd_opcode;
  logic [3:0]        vd_port;
  logic [2:0]        vd_queue;
  logic              vd_dscp_wr;
  logic [5:0]        vd_dscp;
  logic              vd_vlan_wr;
  logic [11:0]       vd_vlan;
  logic              vd_hit;
  logic [IDX_W-1:0]  vd_index;
  logic              cnt_rd_en;
  logic [IDX_W:0]    cnt_rd_addr;
  logic [CNT_W-1:0]  cnt_rd_data;
  logic              cnt_clr_all;
  logic              cnt_busy;
  logic [15:0]       ovf_cnt;

  logic [34:0]       vd_all;
  int                checks;
  int                errors;

  assign vd_all = {vd_valid, vd_opcode, vd_port, vd_queue, vd_dscp_wr, vd_dscp,
                   vd_vlan_wr, vd_vlan, vd_hit, vd_index};

  action_dispatch #(
    .ENTRIES   (ENTRIES),
    .ACTION_W  (64),
    .FIFO_DEPTH(4),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_act_valid  (act_valid),
    .i_act_hit    (act_hit),
    .i_act_index  (act_index),
    .i_act_data   (act_data),
    .i_miss_action(miss_action),
    .o_vd_valid   (vd_valid),
    .i_vd_ready   (vd_ready),
    .o_vd_opcode  (vd_opcode),
    .o_vd_port    (vd_port),
    .o_vd_queue   (vd_queue),
    .o_vd_dscp_wr (vd_dscp_wr),
    .o_vd_dscp    (vd_dscp),
    .o_vd_vlan_wr (vd_vlan_wr),
    .o_vd_vlan    (vd_vlan),
    .o_vd_hit     (vd_hit),
    .o_vd_index   (vd_index),
    .i_cnt_rd_en  (cnt_rd_en),
    .i_cnt_rd_addr(cnt_rd_addr),
    .o_cnt_rd_data(cnt_rd_data),
    .i_cnt_clr_all(cnt_clr_all),
    .o_cnt_busy   (cnt_busy),
    .o_ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk_action(input logic [1:0] op, input logic [3:0] port,
                                            input logic [2:0] q, input logic dw,
                                            input logic [5:0] ds, input logic vw,
                                            input logic [11:0] vl);
    mk_action = {op, port, q, dw, ds, vw, vl, 35'h2A5A5A5A5};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a one-cycle counter read and leave the result on cnt_rd_data.
  task automatic rd_cnt(input logic [IDX_W:0] addr);
    cnt_rd_en   = 1'b1;
    cnt_rd_addr = addr;
    tick();
    cnt_rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; act_valid = 1'b0; act_hit = 1'b0; act_index = '0; act_data = '0;
    miss_action = '0; vd_ready = 1'b0; cnt_rd_en = 1'b0; cnt_rd_addr = '0; cnt_clr_all = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (vd_all !== 35'h0) begin
      errors++; $display("FAIL reset_vd got %h exp %h", vd_all, 35'h0);
    end
    checks++;
    if ({cnt_busy, ovf_cnt, cnt_rd_data} !== 25'h0) begin
      errors++; $display("FAIL reset_misc got busy=%b ovf=%0d rd=%0d exp 0", cnt_busy, ovf_cnt, cnt_rd_data);
    end
    rd_cnt(5'd16);
    checks++;
    if (cnt_rd_data !== 8'd0) begin
      errors++; $display("FAIL reset_miss_cnt got %0d exp 0", cnt_rd_data);
    end
  endtask

  task automatic test_hit();
    vd_ready  = 1'b1;
    act_valid = 1'b1; act_hit = 1'b1; act_index = 4'd3;
    act_data  = mk_action(2'b01, 4'h5, 3'd2, 1'b1, 6'd46, 1'b1, 12'h064);
    tick();
    act_valid = 1'b0;
    checks++;
    if (vd_all !== {1'b1, 2'b01, 4'h5, 3'd2, 1'b1, 6'd46, 1'b1, 12'h064, 1'b1, 4'd3}) begin
      errors++; $display("FAIL hit_verdict got %h exp %h", vd_all,
                         {1'b1, 2'b01, 4'h5, 3'd2, 1'b1, 6'd46, 1'b1, 12'h064, 1'b1, 4'd3});
    end
    rd_cnt(5'd3);
    checks++;
    if ({vd_valid, cnt_rd_data} !== {1'b0, 8'd1}) begin
      errors++; $display("FAIL hit_count got valid=%b cnt=%0d exp valid=0 cnt=1", vd_valid, cnt_rd_data);
    end
  endtask

  task automatic test_miss();
    miss_action = mk_action(2'b10, 4'h9, 3'd7, 1'b0, 6'd0, 1'b1, 12'hABC);
    act_valid = 1'b1; act_hit = 1'b0; act_index = 4'd7; act_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    act_valid = 1'b0;
    checks++;
    if (vd_all !== {1'b1, 2'b10, 4'h9, 3'd7, 1'b0, 6'd0, 1'b1, 12'hABC, 1'b0, 4'd0}) begin
      errors++; $display("FAIL miss_verdict got %h exp %h", vd_all,
                         {1'b1, 2'b10, 4'h9, 3'd7, 1'b0, 6'd0, 1'b1, 12'hABC, 1'b0, 4'd0});
    end
    rd_cnt(5'd16);
    checks++;
    if (cnt_rd_data !== 8'd1) begin
      errors++; $display("FAIL miss_count got %0d exp 1", cnt_rd_data);
    end
    rd_cnt(5'd7);
    checks++;
    if (cnt_rd_data !== 8'd0) begin
      errors++; $display("FAIL miss_no_entry_count got %0d exp 0", cnt_rd_data);
    end
  endtask

  task automatic test_backpressure();
    vd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      act_valid = 1'b1; act_hit = 1'b1; act_index = 4'd5;
      act_data  = mk_action(2'b00, 4'(k), 3'd1, 1'b0, 6'd0, 1'b0, 12'h000);
      tick();
    end
    act_valid = 1'b0;
    checks++;
    if ({vd_valid, ovf_cnt} !== {1'b1, 16'd2}) begin
      errors++; $display("FAIL bp_ovf got valid=%b ovf=%0d exp valid=1 ovf=2", vd_valid, ovf_cnt);
    end
    rd_cnt(5'd5);
    checks++;
    if (cnt_rd_data !== 8'd6) begin
      errors++; $display("FAIL bp_count got %0d exp 6", cnt_rd_data);
    end
    vd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vd_valid, vd_port, vd_index} !== {1'b1, 4'(k), 4'd5}) begin
        errors++; $display("FAIL bp_drain_%0d got valid=%b port=%0d idx=%0d exp valid=1 port=%0d idx=5",
                           k, vd_valid, vd_port, vd_index, k);
      end
      tick();
    end
    checks++;
    if (vd_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got %b exp 0", vd_valid);
    end
  endtask

  task automatic test_full_pop();
    vd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      act_valid = 1'b1; act_hit = 1'b1; act_index = 4'd1;
      act_data  = mk_action(2'b11, 4'(10 + k), 3'd0, 1'b0, 6'd0, 1'b0, 12'h000);
      tick();
    end
    act_data  = mk_action(2'b11, 4'd14, 3'd0, 1'b0, 6'd0, 1'b0, 12'h000);
    vd_ready  = 1'b1;
    checks++;
    if ({vd_valid, vd_port} !== {1'b1, 4'd10}) begin
      errors++; $display("FAIL full_head got valid=%b port=%0d exp valid=1 port=10", vd_valid, vd_port);
    end
    tick();
    act_valid = 1'b0; vd_ready = 1'b0;
    checks++;
    if ({ovf_cnt, vd_port} !== {16'd2, 4'd11}) begin
      errors++; $display("FAIL full_pop got ovf=%0d port=%0d exp ovf=2 port=11", ovf_cnt, vd_port);
    end
    // A further push with no pop only overflows if the FIFO still holds 4.
    act_valid = 1'b1;
    act_data  = mk_action(2'b11, 4'd15, 3'd0, 1'b0, 6'd0, 1'b0, 12'h000);
    tick();
    act_valid = 1'b0;
    checks++;
    if (ovf_cnt !== 16'd3) begin
      errors++; $display("FAIL full_occupancy got ovf=%0d exp 3", ovf_cnt);
    end
    vd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({vd_valid, vd_port} !== {1'b1, 4'(11 + k)}) begin
        errors++; $display("FAIL full_drain_%0d got valid=%b port=%0d exp valid=1 port=%0d",
                           k, vd_valid, vd_port, 11 + k);
      end
      tick();
    end
    checks++;
    if (vd_valid !== 1'b0) begin
      errors++; $display("FAIL full_empty got %b exp 0", vd_valid);
    end
  endtask

  task automatic test_clear_sweep();
    logic [IDX_W:0] addrs [6];
    logic [7:0]     exps  [6];
    int             busy_cycles;
    addrs = '{5'd5, 5'd1, 5'd10, 5'd3, 5'd16, 5'd0};
    exps  = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    rd_cnt(5'd1);
    checks++;
    if (cnt_rd_data !== 8'd6) begin
      errors++; $display("FAIL clr_preload got %0d exp 6", cnt_rd_data);
    end
    vd_ready    = 1'b1;
    cnt_clr_all = 1'b1;
    tick();
    cnt_clr_all = 1'b0;
    busy_cycles = 0;
    for (int c = 1; c < 40; c++) begin
      if (!cnt_busy) break;
      busy_cycles++;
      act_valid = 1'b0; act_hit = 1'b1; cnt_clr_all = 1'b0;
      // c=3: index 10 not yet swept, plus an ignored clear pulse.
      // c=6: index 5 on the very cycle it is swept.  c=8: index 1 already swept.
      if (c == 3) begin act_valid = 1'b1; act_index = 4'd10; cnt_clr_all = 1'b1; end
      if (c == 6) begin act_valid = 1'b1; act_index = 4'd5; end
      if (c == 8) begin act_valid = 1'b1; act_index = 4'd1; end
      tick();
    end
    act_valid = 1'b0; cnt_clr_all = 1'b0;
    checks++;
    if (busy_cycles !== 17) begin
      errors++; $display("FAIL clr_busy_len got %0d exp 17", busy_cycles);
    end
    for (int j = 0; j < 6; j++) begin
      rd_cnt(addrs[j]);
      checks++;
      if (cnt_rd_data !== exps[j]) begin
        errors++; $display("FAIL clr_read_%0d got %0d exp %0d", addrs[j], cnt_rd_data, exps[j]);
      end
    end
  endtask

  task automatic test_read_port();
    cnt_rd_en = 1'b1; cnt_rd_addr = 5'd5;
    act_valid = 1'b1; act_hit = 1'b1; act_index = 4'd5;
    tick();
    cnt_rd_en = 1'b0; act_valid = 1'b0;
    checks++;
    if (cnt_rd_data !== 8'd1) begin
      errors++; $display("FAIL rd_pre_increment got %0d exp 1", cnt_rd_data);
    end
    tick();
    checks++;
    if (cnt_rd_data !== 8'd1) begin
      errors++; $display("FAIL rd_hold got %0d exp 1", cnt_rd_data);
    end
    rd_cnt(5'd5);
    checks++;
    if (cnt_rd_data !== 8'd2) begin
      errors++; $display("FAIL rd_after_inc got %0d exp 2", cnt_rd_data);
    end
    rd_cnt(5'd20);
    checks++;
    if (cnt_rd_data !== 8'd0) begin
      errors++; $display("FAIL rd_out_of_range got %0d exp 0", cnt_rd_data);
    end
  endtask

  task automatic test_saturation();
    vd_ready = 1'b1;
    act_hit = 1'b1; act_index = 4'd0;
    for (int k = 0; k < 254; k++) begin
      act_valid = 1'b1;
      tick();
    end
    act_valid = 1'b0;
    rd_cnt(5'd0);
    checks++;
    if (cnt_rd_data !== 8'd254) begin
      errors++; $display("FAIL sat_preload got %0d exp 254", cnt_rd_data);
    end
    for (int k = 0; k < 3; k++) begin
      act_valid = 1'b1;
      tick();
    end
    act_valid = 1'b0;
    rd_cnt(5'd0);
    checks++;
    if ({ovf_cnt, cnt_rd_data} !== {16'd3, 8'd255}) begin
      errors++; $display("FAIL sat_value got cnt=%0d ovf=%0d exp cnt=255 ovf=3", cnt_rd_data, ovf_cnt);
    end
  endtask

  task automatic test_reset_mid();
    vd_ready = 1'b0;
    act_hit = 1'b1; act_index = 4'd2;
    act_data = mk_action(2'b01, 4'd7, 3'd3, 1'b1, 6'd9, 1'b0, 12'h000);
    act_valid = 1'b1;
    tick(); tick();
    act_valid = 1'b0;
    checks++;
    if (vd_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got %b exp 1", vd_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({vd_all, ovf_cnt, cnt_rd_data, cnt_busy} !== '0) begin
      errors++; $display("FAIL rstmid_state got vd=%h ovf=%0d rd=%0d busy=%b exp all 0",
                         vd_all, ovf_cnt, cnt_rd_data, cnt_busy);
    end
    vd_ready = 1'b1;
    tick();
    rd_cnt(5'd2);
    checks++;
    if ({vd_valid, cnt_rd_data} !== {1'b0, 8'd0}) begin
      errors++; $display("FAIL rstmid_after got valid=%b cnt=%0d exp valid=0 cnt=0", vd_valid, cnt_rd_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_hit();
    test_miss();
    test_backpressure();
    test_full_pop();
    test_clear_sweep();
    test_read_port();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
